pixel_packer: RTL

PIXEL_PACKER -- requirements
Module: pixel_packer

---
 rtl/pixel_packer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pixel_packer.sv
// Pixel packer: assembles pairs of UART bytes into RGB444 pixels for the SPRAM writer.
// A high byte supplies R and G, the low nibble of the next byte supplies B.
// A too-long gap between the two bytes, or the controller leaving the receive
// mode between them, drops the partial pixel and pulses byte_err.
module pixel_packer #(
    parameter logic [7:0]  RECV_STATE  = 8'h02,
    parameter int unsigned PIX_TOTAL   = 16384,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        i_clk_sys,
    input  logic        i_rst_n,
    input  logic [7:0]  state,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_byte,
    output logic        rx_valid,
    output logic [11:0] rx_data,
    output logic [14:0] pix_cnt,
    output logic        frame_done,
    output logic        byte_err
);

    localparam int unsigned CNT_W  = 15;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned GAP_W  = $clog2(TIMEOUT_CYC + 1);

    // Compare against the count *before* increment so PIX_TOTAL=32768 still fits 15 bits.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIX_TOTAL - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_HI = 2'd1,
        S_WAIT_LO = 2'd2,
        S_DONE    = 2'd3
    } fsm_e;

    fsm_e              fsm_q,   fsm_d;
    logic [7:0]        hi_q,    hi_d;
    logic [GAP_W-1:0]  gap_q,   gap_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              valid_q, valid_d;
    logic              done_q,  done_d;
    logic              err_q,   err_d;

    logic in_recv;

    assign in_recv = (state == RECV_STATE);

    // Next-state and registered-output logic; strobes default low every cycle.
    always_comb begin
        fsm_d   = fsm_q;
        hi_d    = hi_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (fsm_q)
            S_IDLE: begin
                if (in_recv) begin
                    fsm_d = S_WAIT_HI;
                    cnt_d = '0;
                end
            end

            S_WAIT_HI: begin
                if (!in_recv) begin
                    fsm_d = S_IDLE;
                end else if (uart_rx_valid) begin
                    hi_d  = uart_rx_byte;
                    gap_d = '0;
                    fsm_d = S_WAIT_LO;
                end
            end

            S_WAIT_LO: begin
                if (!in_recv) begin
                    // Leaving receive mode mid-pixel loses the high byte.
                    fsm_d = S_IDLE;
                    hi_d  = '0;
                    gap_d = '0;
                    err_d = 1'b1;
                end else if (uart_rx_valid) begin
                    // A byte on the timeout cycle still wins over the timeout.
                    valid_d = 1'b1;
                    data_d  = {hi_q, uart_rx_byte[3:0]};
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        done_d = 1'b1;
                        fsm_d  = S_DONE;
                    end else begin
                        fsm_d  = S_WAIT_HI;
                    end
                end else if (gap_q == GAP_LAST) begin
                    fsm_d = S_WAIT_HI;
                    hi_d  = '0;
                    gap_d = '0;
                    err_d = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            S_DONE: begin
                if (!in_recv) begin
                    fsm_d = S_IDLE;
                end
            end

            default: fsm_d = S_IDLE;
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm_q   <= S_IDLE;
            hi_q    <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            hi_q    <= hi_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rx_valid   = valid_q;
    assign rx_data    = data_q;
    assign pix_cnt    = cnt_q;
    assign frame_done = done_q;
    assign byte_err   = err_q;

endmodule
